led_seq: RTL and testbench

LED_SEQ -- requirements
Module: led_seq

---
 rtl/led_seq.sv | 134 +++++++++++++
 tb/tb_led_seq.sv | 139 +++++++++++++
 2 files changed

// File: rtl/led_seq.sv
// LED bounce sequencer: on a start flag, walks one lit LED through a back-and-forth
// pattern for N_STEP steps of TIME_STEP cycles, then raises a done flag. Macro LED_ACTIVE_LOW_EN inverts the LED drive.
module led_seq #(
    parameter logic [31:0] TIME_STEP = 32'd5_000_000,
    parameter logic [7:0]  N_STEP    = 8'd8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fs,
    output logic       fd,
    output logic [3:0] led
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] cyc_q;
    logic [7:0]  step_q;
    logic [3:0]  pat_q;
    logic        dir_up_q;
    logic [3:0]  led_q;
    logic        fd_q;

    logic [3:0]  pat_d;
    logic        dir_up_d;
    logic        last_cyc_d;
    logic        last_step_d;

    // Electrical LED drive for an active-high pattern.
    function automatic logic [3:0] drive_led(input logic [3:0] pat);
`ifdef LED_ACTIVE_LOW_EN
        return ~pat;
`else
        return pat;
`endif
    endfunction

    // Next bounce position and direction, plus end-of-step / end-of-run detection.
    always_comb begin
        pat_d       = pat_q;
        dir_up_d    = dir_up_q;
        last_cyc_d  = (cyc_q == (TIME_STEP - 32'd1));
        last_step_d = (step_q == (N_STEP - 8'd1));
        if (dir_up_q) begin
            pat_d    = {pat_q[2:0], 1'b0};
            dir_up_d = (pat_d != 4'b1000);
        end else begin
            pat_d    = {1'b0, pat_q[3:1]};
            dir_up_d = (pat_d == 4'b0001);
        end
    end

    // Sequencer FSM with counters and registered LED / done outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cyc_q    <= 32'd0;
            step_q   <= 8'd0;
            pat_q    <= 4'b0001;
            dir_up_q <= 1'b1;
            led_q    <= drive_led(4'b0000);
            fd_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cyc_q    <= 32'd0;
                    step_q   <= 8'd0;
                    pat_q    <= 4'b0001;
                    dir_up_q <= 1'b1;
                    fd_q     <= 1'b0;
                    if (fs) begin
                        state_q <= S_RUN;
                        led_q   <= drive_led(4'b0001);
                    end else begin
                        state_q <= S_IDLE;
                        led_q   <= drive_led(4'b0000);
                    end
                end
                S_RUN: begin
                    // A dropped start flag aborts even on the final cycle.
                    if (!fs) begin
                        state_q <= S_IDLE;
                        led_q   <= drive_led(4'b0000);
                        fd_q    <= 1'b0;
                    end else if (last_cyc_d) begin
                        cyc_q <= 32'd0;
                        if (last_step_d) begin
                            state_q <= S_DONE;
                            led_q   <= drive_led(4'b0000);
                            fd_q    <= 1'b1;
                        end else begin
                            state_q  <= S_RUN;
                            step_q   <= step_q + 8'd1;
                            pat_q    <= pat_d;
                            dir_up_q <= dir_up_d;
                            led_q    <= drive_led(pat_d);
                            fd_q     <= 1'b0;
                        end
                    end else begin
                        state_q <= S_RUN;
                        cyc_q   <= cyc_q + 32'd1;
                    end
                end
                S_DONE: begin
                    led_q <= drive_led(4'b0000);
                    if (fs) begin
                        state_q <= S_DONE;
                        fd_q    <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        fd_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    cyc_q    <= 32'd0;
                    step_q   <= 8'd0;
                    pat_q    <= 4'b0001;
                    dir_up_q <= 1'b1;
                    led_q    <= drive_led(4'b0000);
                    fd_q     <= 1'b0;
                end
            endcase
        end
    end

    assign led = led_q;
    assign fd  = fd_q;

endmodule

// File: tb/tb_led_seq.sv
// Bench for led_seq (TIME_STEP=4, N_STEP=6): directed vector table, then random
// fs/rst_n traffic checked against an elapsed-time reference model.
module tb_led_seq;

    localparam int TS = 4;
    localparam int NS = 6;

    logic       clk;
    logic       rst_n;
    logic       fs;
    logic       fd;
    logic [3:0] led;

    int n_vec;
    int n_miss;

    led_seq #(.TIME_STEP(32'd4), .N_STEP(8'd6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fs    (fs),
        .fd    (fd),
        .led   (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       fs;
        logic [3:0] led;
        logic       fd;
        string      name;
    } vec_t;

    vec_t tbl[$];
    logic [3:0] bounce [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};

    function automatic logic [3:0] drv(input logic [3:0] pat);
`ifdef LED_ACTIVE_LOW_EN
        return ~pat;
`else
        return pat;
`endif
    endfunction

    task automatic add(input logic r, input logic f, input logic [3:0] el, input logic ef, input string nm);
        vec_t v;
        v.rst_n = r; v.fs = f; v.led = el; v.fd = ef; v.name = nm;
        tbl.push_back(v);
    endtask

    task automatic apply(input logic r, input logic f, input logic [3:0] el, input logic ef, input string nm);
        rst_n = r;
        fs    = f;
        @(posedge clk);
        #1;
        n_vec++;
        if (led !== el || fd !== ef) begin
            n_miss++;
            $display("FAIL %s vec %0d: got led=%b fd=%b, expected led=%b fd=%b", nm, n_vec, led, fd, el, ef);
        end
    endtask

    initial begin
        int  m_mode;   // 0 idle, 1 running, 2 done
        int  m_t;      // cycles elapsed since the run started
        logic r, f;
        logic [3:0] el;
        logic ef;

        n_vec = 0;
        n_miss = 0;
        rst_n = 1'b0;
        fs = 1'b0;

        // Reset held three cycles, then released with fs low.
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, drv(4'b0000), 1'b0, "reset");
        for (int i = 0; i < 2; i++) add(1'b1, 1'b0, drv(4'b0000), 1'b0, "post_reset");

        // Full run: output cycle c uses fs from cycle c-1; fs drops at cycle 30.
        for (int c = 1; c <= 31; c++) begin
            if (c <= 24)      add(1'b1, 1'b1, drv(bounce[(c - 1) / TS]), 1'b0, "full_run");
            else if (c <= 30) add(1'b1, 1'b1, drv(4'b0000), 1'b1, "done_hold");
            else              add(1'b1, 1'b0, drv(4'b0000), 1'b0, "done_release");
        end
        for (int i = 0; i < 2; i++) add(1'b1, 1'b0, drv(4'b0000), 1'b0, "idle_gap");

        // Abort at cycle 10, restart at cycle 20.
        for (int c = 1; c <= 25; c++) begin
            if (c <= 10)      add(1'b1, 1'b1, drv(bounce[(c - 1) / TS]), 1'b0, "pre_abort");
            else if (c <= 20) add(1'b1, (c >= 21), drv(4'b0000), 1'b0, "abort_idle");
            else              add(1'b1, 1'b1, drv(bounce[(c - 21) / TS]), 1'b0, "restart");
        end
        add(1'b1, 1'b0, drv(4'b0000), 1'b0, "restart_abort");

        // fs drops on the final RUN cycle: no done flag.
        for (int c = 1; c <= 27; c++) begin
            if (c <= 24) add(1'b1, 1'b1, drv(bounce[(c - 1) / TS]), 1'b0, "late_run");
            else         add(1'b1, 1'b0, drv(4'b0000), 1'b0, "late_abort");
        end

        // Reset asserted mid-run at cycle 14; nothing resumes afterwards.
        for (int c = 1; c <= 14; c++) add(1'b1, 1'b1, drv(bounce[(c - 1) / TS]), 1'b0, "pre_reset_run");
        add(1'b0, 1'b1, drv(4'b0000), 1'b0, "mid_run_reset");
        add(1'b1, 1'b0, drv(4'b0000), 1'b0, "no_resume");
        add(1'b1, 1'b1, drv(4'b0001), 1'b0, "fresh_start");
        add(1'b1, 1'b0, drv(4'b0000), 1'b0, "fresh_abort");

        foreach (tbl[i]) apply(tbl[i].rst_n, tbl[i].fs, tbl[i].led, tbl[i].fd, tbl[i].name);

        // Random traffic against the reference model; the table leaves the DUT idle.
        m_mode = 0;
        m_t = 0;
        f = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) f = ~f;
            r = ($urandom_range(0, 199) != 0);
            if (!r) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (f) begin m_mode = 1; m_t = 0; end
            end else if (m_mode == 1) begin
                if (!f)                     m_mode = 0;
                else if (m_t == NS * TS - 1) m_mode = 2;
                else                        m_t++;
            end else begin
                if (!f) m_mode = 0;
            end
            el = (m_mode == 1) ? drv(bounce[(m_t / TS) % 6]) : drv(4'b0000);
            ef = (m_mode == 2);
            apply(r, f, el, ef, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
